// File: rtl/mat_mult_host_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mat_mult_host_ctrl                                         |
// | Description : Host-side sequencer for the 4x4-block complex matrix       |
// |               multiplier. Streams 512 operand beats into the multiplier  |
// |               load port (index 1..512), waits for mm_done, then sweeps   |
// |               index 0..511 and returns the results as a valid/ready      |
// |               stream. The multiplier is held in reset before each job.   |
// | Ports       : clk, rst            clock / sync active-high reset         |
// |               in_valid/in_ready   operand beat handshake, in_a, in_b     |
// |               out_valid/out_ready result handshake, out_data, out_last   |
// |               busy, err_timeout   status (err_timeout is sticky)         |
// |               mm_*                multiplier load/read/reset interface   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mat_mult_host_ctrl #(
    parameter int TIMEOUT  = 4096,
    parameter int CLR_CYC  = 2,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err_timeout,
    output logic        mm_rst_n,
    output logic        mm_en,
    output logic [31:0] mm_index,
    output logic [31:0] mm_a,
    output logic [31:0] mm_b,
    input  logic [31:0] mm_sum,
    input  logic        mm_done
);

    localparam logic [2:0] c_CLEAR = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_RADDR = 3'd3;
    localparam logic [2:0] c_RCAP  = 3'd4;
    localparam logic [2:0] c_OUT   = 3'd5;

    localparam int c_TO_W  = $clog2(TIMEOUT + 1);
    localparam int c_CLR_W = $clog2(CLR_CYC + 1);
    localparam int c_LAT_W = $clog2(READ_LAT + 1);

    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_CLR_W-1:0] c_CLR_LAST = c_CLR_W'(CLR_CYC - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(READ_LAT - 1);

    logic [2:0]         r_state;
    logic [c_CLR_W-1:0] r_clr_cnt;
    logic [9:0]         r_beat;
    logic [c_TO_W-1:0]  r_wait_cnt;
    logic [8:0]         r_rd;
    logic [c_LAT_W-1:0] r_lat;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_err_timeout;
    logic               r_mm_rst_n;
    logic               r_mm_en;
    logic [31:0]        r_out_data;
    logic [31:0]        r_mm_index;
    logic [31:0]        r_mm_a;
    logic [31:0]        r_mm_b;
    logic               w_in_fire;

    assign w_in_fire = in_valid && r_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_CLEAR;
            r_clr_cnt     <= '0;
            r_beat        <= '0;
            r_wait_cnt    <= '0;
            r_rd          <= '0;
            r_lat         <= '0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_mm_rst_n    <= 1'b0;
            r_mm_en       <= 1'b0;
            r_out_data    <= '0;
            r_mm_index    <= '0;
            r_mm_a        <= '0;
            r_mm_b        <= '0;
        end else begin
            case (r_state)
                c_CLEAR: begin
                    r_mm_rst_n <= 1'b0;
                    r_mm_en    <= 1'b0;
                    r_in_ready <= 1'b0;
                    if (r_clr_cnt == c_CLR_LAST) begin
                        // Release the multiplier and open the operand port together
                        r_clr_cnt  <= '0;
                        r_beat     <= '0;
                        r_mm_rst_n <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= c_LOAD;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + c_CLR_W'(1);
                    end
                end
                c_LOAD: begin
                    if (w_in_fire) begin
                        // Load index is one-based: beat n lands at index n+1
                        r_mm_en    <= 1'b1;
                        r_mm_index <= 32'(r_beat) + 32'd1;
                        r_mm_b     <= in_b;
                        r_mm_a     <= (r_beat < 10'd32) ? in_a : 32'd0;
                        r_beat     <= r_beat + 10'd1;
                        if (r_beat == 10'd511) begin
                            r_in_ready <= 1'b0;
                            r_wait_cnt <= '0;
                            r_state    <= c_WAIT;
                        end
                    end else begin
                        r_mm_en <= 1'b0;
                    end
                end
                c_WAIT: begin
                    r_mm_en <= 1'b0;
                    // Timeout is tested first so it wins a same-edge mm_done
                    if (r_wait_cnt == c_TO_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_wait_cnt    <= '0;
                        r_clr_cnt     <= '0;
                        r_mm_rst_n    <= 1'b0;
                        r_state       <= c_CLEAR;
                    end else if (mm_done) begin
                        r_wait_cnt <= '0;
                        r_rd       <= '0;
                        r_lat      <= '0;
                        r_state    <= c_RADDR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
                    end
                end
                c_RADDR: begin
                    // Index is re-registered every cycle here; it stays equal to r
                    r_mm_index <= 32'(r_rd);
                    if (r_lat == c_LAT_LAST) begin
                        r_lat   <= '0;
                        r_state <= c_RCAP;
                    end else begin
                        r_lat <= r_lat + c_LAT_W'(1);
                    end
                end
                c_RCAP: begin
                    r_out_data  <= mm_sum;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_rd == 9'd511);
                    r_state     <= c_OUT;
                end
                c_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_rd == 9'd511) begin
                            r_clr_cnt  <= '0;
                            r_mm_rst_n <= 1'b0;
                            r_state    <= c_CLEAR;
                        end else begin
                            r_rd    <= r_rd + 9'd1;
                            r_state <= c_RADDR;
                        end
                    end
                end
                default: begin
                    r_clr_cnt  <= '0;
                    r_mm_rst_n <= 1'b0;
                    r_state    <= c_CLEAR;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign err_timeout = r_err_timeout;
    assign mm_rst_n    = r_mm_rst_n;
    assign mm_en       = r_mm_en;
    assign mm_index    = r_mm_index;
    assign mm_a        = r_mm_a;
    assign mm_b        = r_mm_b;
    // Idle means waiting in LOAD before the first beat of a job
    assign busy        = !((r_state == c_LOAD) && (r_beat == 10'd0));

endmodule
`default_nettype wire

// File: tb/tb_mat_mult_host_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mat_mult_host_ctrl                                      |
// | Description : Self-checking bench for mat_mult_host_ctrl with a          |
// |               behavioural multiplier model and load/read scoreboards.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mat_mult_host_ctrl;

    localparam int c_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err_timeout;
    logic        mm_rst_n;
    logic        mm_en;
    logic [31:0] mm_index;
    logic [31:0] mm_a;
    logic [31:0] mm_b;
    logic [31:0] mm_sum;
    logic        mm_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_delay = -1;
    logic armed = 1'b0;
    int   dcnt  = 0;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] a;
        logic [31:0] b;
    } ld_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] data;
        logic        last;
    } rd_t;

    ld_t ldq[$];
    rd_t rdq[$];

    mat_mult_host_ctrl #(
        .TIMEOUT  (c_TIMEOUT),
        .CLR_CYC  (2),
        .READ_LAT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .err_timeout (err_timeout),
        .mm_rst_n    (mm_rst_n),
        .mm_en       (mm_en),
        .mm_index    (mm_index),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_sum      (mm_sum),
        .mm_done     (mm_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Multiplier model: registered read data, done raised done_delay cycles
    // after the index-512 write is seen (never when done_delay < 0).
    always @(posedge clk) begin
        mm_sum <= mm_index * 32'd3;
        if (mm_rst_n !== 1'b1) begin
            armed   <= 1'b0;
            dcnt    <= 0;
            mm_done <= 1'b0;
        end else if (mm_en === 1'b1 && mm_index == 32'd512) begin
            armed <= 1'b1;
            dcnt  <= 1;
        end else if (armed) begin
            dcnt <= dcnt + 1;
            if (done_delay >= 0 && dcnt + 1 == done_delay) mm_done <= 1'b1;
        end
    end

    // Load-port scoreboard: every cycle with mm_en high is one write
    always @(negedge clk) begin
        if (mm_en === 1'b1) begin
            wr_cnt++;
            if (ldq.size() == 0) begin
                chk1("spurious_write", mm_en, 1'b0);
            end else begin
                chk("load_index", mm_index, ldq[0].idx);
                chk("load_a", mm_a, ldq[0].a);
                chk("load_b", mm_b, ldq[0].b);
                void'(ldq.pop_front());
            end
        end
    end

    // Result scoreboard: checked on every valid cycle, popped on handshake
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (rdq.size() == 0) begin
                chk1("spurious_out", out_valid, 1'b0);
            end else begin
                chk("out_data", out_data, rdq[0].data);
                chk1("out_last", out_last, rdq[0].last);
                chk("rd_index", mm_index, rdq[0].idx);
                if (out_ready === 1'b1) void'(rdq.pop_front());
            end
        end else if (out_last !== 1'b0) begin
            chk1("last_without_valid", out_last, 1'b0);
        end
    end

    task automatic send_job(input int n_beats, input int gap);
        int g;
        for (int n = 0; n < n_beats; n++) begin
            if (gap > 0 && n > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_a     = n;
            in_b     = 1000 + n;
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (in_ready !== 1'b1 && g < 3000);
            if (in_ready !== 1'b1) begin
                chk1("in_ready_wait", in_ready, 1'b1);
                in_valid = 1'b0;
                return;
            end
            ldq.push_back('{idx: 32'(n + 1), a: (n < 32) ? 32'(n) : 32'd0, b: 32'(1000 + n)});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic push_reads();
        for (int k = 0; k < 512; k++)
            rdq.push_back('{idx: 32'(k), data: 32'(3 * k), last: (k == 511)});
    endtask

    task automatic wait_reads();
        int g;
        g = 0;
        while (rdq.size() != 0 && g < 8000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("reads_drained", rdq.size(), 32'd0);
    endtask

    task automatic check_clear_tail();
        chk1("end_rst_n_c1", mm_rst_n, 1'b0);
        chk1("end_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk1("end_rst_n_c2", mm_rst_n, 1'b0);
        @(posedge clk); #1;
        chk1("end_rst_n_rel", mm_rst_n, 1'b1);
        chk1("end_in_ready", in_ready, 1'b1);
    endtask

    task automatic check_reset_outputs();
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk1("rst_out_last", out_last, 1'b0);
        chk1("rst_err_timeout", err_timeout, 1'b0);
        chk1("rst_mm_rst_n", mm_rst_n, 1'b0);
        chk1("rst_mm_en", mm_en, 1'b0);
        chk("rst_mm_index", mm_index, 32'd0);
        chk("rst_mm_a", mm_a, 32'd0);
        chk("rst_mm_b", mm_b, 32'd0);
        chk1("rst_busy", busy, 1'b1);
    endtask

    // Expects to be called one cycle after the last beat was accepted
    task automatic timeout_window(input string tag);
        for (int k = 1; k <= c_TIMEOUT; k++) begin
            @(posedge clk); #1;
            if (k == c_TIMEOUT - 1) chk1({tag, "_err_early"}, err_timeout, 1'b0);
            if (k == c_TIMEOUT) begin
                chk1({tag, "_err_set"}, err_timeout, 1'b1);
                chk1({tag, "_abort_rst_n"}, mm_rst_n, 1'b0);
            end
        end
    endtask

    initial begin
        int g;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs();

        // CLEAR holds the multiplier in reset for two cycles after rst drops
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("clr_rst_n", mm_rst_n, 1'b0);
        chk1("clr_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("load_rst_n", mm_rst_n, 1'b1);
        chk1("load_in_ready", in_ready, 1'b1);
        chk1("idle_busy", busy, 1'b0);

        // Nominal job
        push_reads(); done_delay = 50; wr_cnt = 0;
        send_job(512, 0);
        chk1("job1_busy", busy, 1'b1);
        chk1("job1_in_ready_off", in_ready, 1'b0);
        wait_reads();
        chk("job1_writes", wr_cnt, 32'd512);
        check_clear_tail();

        // Input gaps plus backpressure on word 5
        push_reads(); done_delay = 50; wr_cnt = 0; out_ready = 1'b0;
        send_job(512, 2);
        for (int w = 0; w < 6; w++) begin
            g = 0;
            while (out_valid !== 1'b1 && g < 3000) begin @(posedge clk); #1; g++; end
            if (w == 5) begin
                repeat (10) begin @(posedge clk); #1; end
                chk("stall_data", out_data, 32'd15);
                chk("stall_index", mm_index, 32'd5);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
        wait_reads();
        chk("job2_writes", wr_cnt, 32'd512);
        check_clear_tail();

        // Timeout: mm_done never rises
        done_delay = -1; wr_cnt = 0;
        send_job(512, 0);
        timeout_window("to");
        chk("to_writes", wr_cnt, 32'd512);

        // Next load is accepted; reset mid-load at beat 200
        wr_cnt = 0;
        send_job(200, 0);
        chk1("err_sticky", err_timeout, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs();
        chk("midrst_writes", wr_cnt, 32'd200);
        rst = 1'b0;

        // Job after reset starts from index 1 and completes
        push_reads(); done_delay = 50; wr_cnt = 0;
        send_job(512, 0);
        wait_reads();
        chk("job5_writes", wr_cnt, 32'd512);
        check_clear_tail();

        // mm_done arrives on the timeout edge: abort wins
        done_delay = c_TIMEOUT - 1;
        send_job(512, 0);
        timeout_window("coll");
        repeat (30) begin @(posedge clk); #1; end
        chk1("coll_no_output", out_valid, 1'b0);
        chk("coll_load_empty", ldq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
